// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding, fetch constants and the fetch-address legality helper.
// Used by the fetch RTL and by the processor-level bench.
package fetch_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES        = 4;
   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_0000;

   // A fetch address is legal when word aligned and no higher than the
   // last whole word in instruction memory.
   function automatic logic fetch_addr_legal(input logic [31:0] addr,
                                             input logic [31:0] last_addr);
      return (addr[1:0] == 2'b00) && (addr <= last_addr);
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch controller.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (pc <= RESET_PC)
//   load         - load pc from load_pc (takes priority over incr)
//   incr         - advance pc by one instruction word
//   load_pc      - candidate redirect target
//   pc           - current program counter
//   pc_in_range  - pc addresses a whole word inside instruction memory
//   load_pc_ok   - load_pc is aligned and inside instruction memory
module fetch_pc_reg
   import fetch_controller_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned IMEM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        incr,
   input  logic [31:0] load_pc,
   output logic [31:0] pc,
   output logic        pc_in_range,
   output logic        load_pc_ok
);

   localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - INSTR_BYTES);

   always_ff @(posedge clk) begin
      if (reset)
         pc <= RESET_PC;
      else if (load)
         pc <= load_pc;
      else if (incr)
         pc <= pc + 32'(INSTR_BYTES);
   end

   assign pc_in_range = fetch_addr_legal(pc, LAST_ADDR);
   assign load_pc_ok  = fetch_addr_legal(load_pc, LAST_ADDR);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the PC, drives the combinational
// instruction memory address and registers fetched words into IF/ID.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start               - pulse to leave IDLE and begin fetching
//   stall               - freeze PC and IF/ID contents
//   redirect_valid/_pc  - taken branch from EX: flush and load new PC
//   imem_addr/imem_instr- instruction memory address / returned word
//   if_valid/if_pc/if_instr - IF/ID register
//   halted              - halt word reached (sticky)
//   fault, fault_pc     - illegal fetch address seen (sticky) and its value
//   fetch_count         - number of words issued into IF/ID
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned IMEM_BYTES = 4096,
   parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        halted,
   output logic        fault,
   output logic [31:0] fault_pc,
   output logic [31:0] fetch_count
);

   fetch_state_t state_q, state_d;

   logic [31:0] pc;
   logic        pc_in_range;
   logic        redirect_ok;
   logic        pc_load;
   logic        pc_incr;
   logic        issue;
   logic        kill;
   logic        set_halt;
   logic        set_fault;
   logic [31:0] fault_addr;

   fetch_pc_reg #(
      .RESET_PC   (RESET_PC),
      .IMEM_BYTES (IMEM_BYTES)
   ) u_pc (
      .clk         (clk),
      .reset       (reset),
      .load        (pc_load),
      .incr        (pc_incr),
      .load_pc     (redirect_pc),
      .pc          (pc),
      .pc_in_range (pc_in_range),
      .load_pc_ok  (redirect_ok)
   );

   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Priority in RUN: redirect, then stall, then halt check, range check, issue.
   always_comb begin
      state_d    = state_q;
      pc_load    = 1'b0;
      pc_incr    = 1'b0;
      issue      = 1'b0;
      kill       = 1'b0;
      set_halt   = 1'b0;
      set_fault  = 1'b0;
      fault_addr = pc;
      case (state_q)
         ST_IDLE: begin
            if (start)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_valid) begin
               kill = 1'b1;
               if (redirect_ok) begin
                  pc_load = 1'b1;
               end else begin
                  set_fault  = 1'b1;
                  fault_addr = redirect_pc;
                  state_d    = ST_FAULT;
               end
            end else if (!stall) begin
               if (imem_instr == HALT_INSTR) begin
                  kill     = 1'b1;
                  set_halt = 1'b1;
                  state_d  = ST_HALT;
               end else if (!pc_in_range) begin
                  kill      = 1'b1;
                  set_fault = 1'b1;
                  state_d   = ST_FAULT;
               end else begin
                  issue   = 1'b1;
                  pc_incr = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_valid    <= 1'b0;
         if_pc       <= '0;
         if_instr    <= '0;
         halted      <= 1'b0;
         fault       <= 1'b0;
         fault_pc    <= '0;
         fetch_count <= '0;
      end else begin
         if (kill)
            if_valid <= 1'b0;
         if (issue) begin
            if_valid    <= 1'b1;
            if_pc       <= pc;
            if_instr    <= imem_instr;
            fetch_count <= fetch_count + 32'd1;
         end
         if (set_halt)
            halted <= 1'b1;
         if (set_fault) begin
            fault    <= 1'b1;
            fault_pc <= fault_addr;
         end
      end
   end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the byte-addressable, combinational-read instruction memory (4 KB, little-endian, 32-bit words at byte addresses) for the pipelined processor.
- Owns the PC and drives the memory address.
- Registers the fetched word into the IF/ID stage with a valid flag.
- Handles stall, branch redirect/flush, halt detection and out-of-range/misaligned fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 4096, instruction memory size in bytes; last legal fetch address is IMEM_BYTES-4.
- HALT_INSTR, 32'h0000_0000, instruction word that terminates fetch (blank memory reads as this).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse to begin fetching from IDLE.
- stall  in  1  hazard stall from the pipeline; freezes PC and IF/ID outputs.
- redirect_valid  in  1  taken branch/jump from EX; flush and load new PC.
- redirect_pc  in  32  target byte address for the redirect.
- imem_addr  out  32  byte address to instruction memory; combinational copy of PC.
- imem_instr  in  32  word returned combinationally by instruction memory.
- if_valid  out  1  IF/ID register holds a live instruction.
- if_pc  out  32  byte address of if_instr.
- if_instr  out  32  registered instruction word.
- halted  out  1  HALT_INSTR reached; sticky.
- fault  out  1  illegal fetch address; sticky.
- fault_pc  out  32  offending address.
- fetch_count  out  32  number of instructions issued (if_valid rising into a new word).

Behaviour:
- FSM states: IDLE, RUN, HALT, FAULT.
- Reset (takes effect at any state, including mid-RUN with stall or redirect asserted): state=IDLE, pc=RESET_PC. All registered outputs are 0: if_valid, if_pc, if_instr, halted, fault, fault_pc, fetch_count.
- imem_addr = pc at all times, including in IDLE, HALT and FAULT.
- IDLE: outputs held. start=1 moves to RUN next cycle. No fetch is issued in the cycle start is seen.
- RUN, priority redirect > stall > normal:
  - Redirect: if_valid<=0 (flush the wrong-path word). If redirect_pc[1:0]!=0 or redirect_pc>IMEM_BYTES-4: go to FAULT, fault_pc<=redirect_pc, pc unchanged. Otherwise pc<=redirect_pc. Redirect overrides a simultaneous stall.
  - Stall (no redirect): pc, if_valid, if_pc, if_instr and fetch_count all hold.
  - Normal, halt check: if imem_instr==HALT_INSTR, go to HALT, halted<=1, if_valid<=0, pc holds. The halt word is not issued and not counted.
  - Normal, range check: else if pc>IMEM_BYTES-4, go to FAULT, fault<=1, fault_pc<=pc, if_valid<=0.
  - Normal, issue: else if_valid<=1, if_pc<=pc, if_instr<=imem_instr, pc<=pc+4, fetch_count<=fetch_count+1.
- Latency: a word at address A appears on if_* in the cycle after pc==A with no stall or redirect. Throughput is 1 word/cycle.
- pc arithmetic is 32-bit unsigned. The range check is made before the increment, so pc never wraps past IMEM_BYTES. fetch_count wraps modulo 2^32.
- HALT and FAULT are terminal until reset; start, stall and redirect are ignored. halted and fault are never both 1.
- start while in RUN/HALT/FAULT is ignored.

Decomposition:
- Shared package (used by the processor top and the bench) holds:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, HALT=2'd2, FAULT=2'd3.
  - Constants: INSTR_BYTES=4, DEFAULT_RESET_PC, DEFAULT_HALT_INSTR.
- One natural sub-module, fetch_pc_reg: the PC register with load/increment/hold plus the alignment and range check. The FSM and the IF/ID register stay in fetch_controller.

Test Plan:
- Memory {0:32'h00500093, 4:32'h00a00113, 8:32'h0}, reset then start → if_pc 0,4 on consecutive cycles with matching if_instr. Then halted=1, if_valid=0, fetch_count=2.
- stall held 3 cycles while if_pc=4 → if_pc/if_instr/fetch_count frozen for 3 cycles. pc=8 resumes the cycle after stall drops.
- redirect_valid with redirect_pc=32'h40 while stall=1 → next cycle if_valid=0, imem_addr=32'h40. The following cycle if_pc=32'h40.
- redirect_pc=32'h42 → fault=1, fault_pc=32'h42, if_valid=0. Subsequent start/redirect ignored.
- Memory with no halt word, run to pc=4092 → word at 4092 issued, then fault=1 with fault_pc=4096.
- reset asserted mid-RUN with stall=1 → next cycle state IDLE, pc=RESET_PC, all outputs 0. Re-start fetches from 0.
